zero_cross_period: RTL and testbench
====================================

// Module: zero_cross_period
// PURPOSE
//   Frequency-measurement stage fed by the udelay sample delay line.
//   Compares the current sample with its one-sample-delayed copy and tracks sign with hysteresis.
//   Counts valid samples between accepted rising zero crossings and reports the period.
//   The period feeds the downstream signal-separation / DDS-tuning logic.
// PARAMETERS
//   WIDTH       16  sample width, signed two's complement
//   CNT_W       24  period counter width; CNT_MAX = 2**CNT_W-1
//   HYST        64  hysteresis threshold, signed, 0 < HYST < 2**(WIDTH-1)
//   MIN_PERIOD   4  shortest accepted period in samples; shorter crossings are glitches
// PORTS
//   clk          in   1        system clock, all logic on rising edge
//   rst          in   1        reset, asynchronous, active-high
//   sample_vld   in   1        qualifies sample_cur/sample_prev; one sample per high cycle
//   sample_cur   in   WIDTH    current sample (signed)
//   sample_prev  in   WIDTH    previous sample, taken from udelay delay_out (signed)
//   period_out   out  CNT_W    last measured period in samples; held between updates
//   period_vld   out  1        1-cycle pulse; period_out is new
//   timeout      out  1        1-cycle pulse; counter saturated, no crossing seen
//   locked       out  1        level; at least one period has been reported since the last timeout/reset
// BEHAVIOUR
//   Reset (async, any time, incl. mid-count): all outputs 0, cnt=0, armed=0, state=S_INIT.
//   Only cycles with sample_vld=1 advance state/cnt; otherwise everything holds.
//   hi = (cur>=HYST)&&(prev>=HYST); lo = (cur<=-HYST)&&(prev<=-HYST); signed compares.
//   FSM (2-bit): S_INIT: hi->S_POS, lo->S_NEG, else stay.
//     S_NEG: hi -> S_POS and rising event (REV); else stay.
//     S_POS: lo -> S_NEG; else stay.  hi&&lo is impossible (HYST>0).
//   cnt: on every valid sample without an accepted REV, cnt <= sat(cnt+1).
//   REV handling (evaluated in this order):
//     armed=0 or cnt==CNT_MAX: no pulse; armed<=1; cnt<=0   (first edge / re-arm)
//     cnt+1 < MIN_PERIOD: glitch; state->S_POS; cnt keeps counting; no pulse
//     else: period_out<=cnt+1; period_vld<=1; locked<=1; cnt<=0
//   Latency: period_vld is registered, high the cycle after the triggering valid sample.
//   Saturation: when cnt increments into CNT_MAX -> timeout pulse once, armed<=0, locked<=0.
//     cnt stays at CNT_MAX; no further timeout pulses until the next REV clears it.
//   REV and saturation in the same sample: REV wins (first-edge branch); no timeout pulse.
//   period_out is never cleared except by rst; width rule: cnt+1 computed in CNT_W bits,
//     cannot overflow because cnt<CNT_MAX on the reporting branch.
// STRUCTURE
//   zc_defs.vh: localparams S_INIT=2'd0, S_NEG=2'd1, S_POS=2'd2; shared with the
//     downstream tuning block.
//   Sub-module zc_sat_cnt: CNT_W saturating counter with clear, enable and at_max flag.
//   Top: comparators, FSM, armed/locked flags, output registers.
// TESTING
//   1 Square wave +1000/-1000, period 8 samples, vld every cycle -> 1st rise no pulse; then period_out=8 each rise, locked=1.
//   2 Same wave, vld every 3rd cycle -> period_out=8; period_vld one cycle after the rising sample.
//   3 Single +1000 spike inside the -1000 half (cur only) -> no REV (prev fails hi), period unchanged.
//   4 Noise +-50 around 0 with HYST=64 -> state stays S_INIT, no pulses ever.
//   5 Rising edge 2 samples after the accepted edge (MIN_PERIOD=4) -> no pulse; next valid edge at 10 -> period_out=10.
//   6 CNT_W=8, DC -1000 for 300 samples -> timeout pulse at sample 255, locked=0;
//     next two rises -> first re-arms, second reports; rst mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/zero_cross_period_pkg.sv
// Shared definitions for the zero-crossing period meter: sign-tracking states
// and the state transition rule (also used by the downstream tuning block).
package zero_cross_period_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_NEG  = 2'd1,
        S_POS  = 2'd2
    } zc_state_e;

    // hi and lo are mutually exclusive because the threshold is strictly positive.
    function automatic zc_state_e zc_next_state(input zc_state_e s, input logic hi, input logic lo);
        zc_state_e n;
        n = s;
        case (s)
            S_INIT: begin
                if (hi)
                    n = S_POS;
                else if (lo)
                    n = S_NEG;
            end
            S_NEG:   if (hi) n = S_POS;
            S_POS:   if (lo) n = S_NEG;
            default: n = S_INIT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/zero_cross_period_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable; flags full scale
// and one-below-full-scale so the caller can see saturation coming.
module zero_cross_period_sat_cnt #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_max,
    output logic             near_max
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt      = cnt_q;
    assign at_max   = (cnt_q == CNT_MAX);
    assign near_max = (cnt_q == CNT_NEAR);

endmodule

// File: rtl/zero_cross_period.sv
// Zero-crossing period meter: hysteretic sign tracking on current/delayed
// samples, counts valid samples between accepted rising crossings.
module zero_cross_period
    import zero_cross_period_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 24,
    parameter int HYST       = 64,
    parameter int MIN_PERIOD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_vld,
    input  logic signed [WIDTH-1:0] sample_cur,
    input  logic signed [WIDTH-1:0] sample_prev,
    output logic        [CNT_W-1:0] period_out,
    output logic                    period_vld,
    output logic                    timeout,
    output logic                    locked
);

    localparam logic signed [WIDTH-1:0] HYST_POS = WIDTH'(HYST);
    localparam logic signed [WIDTH-1:0] HYST_NEG = -HYST_POS;
    localparam logic        [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);

    zc_state_e        state_q, state_d;
    logic             armed_q, armed_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvld_q, pvld_d;
    logic             tout_q, tout_d;

    logic             hi, lo, rev;
    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             at_max, near_max;

    zero_cross_period_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .cnt      (cnt),
        .at_max   (at_max),
        .near_max (near_max)
    );

    assign hi      = (sample_cur >= HYST_POS) && (sample_prev >= HYST_POS);
    assign lo      = (sample_cur <= HYST_NEG) && (sample_prev <= HYST_NEG);
    assign rev     = (state_q == S_NEG) && hi;
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        locked_d = locked_q;
        period_d = period_q;
        pvld_d   = 1'b0;
        tout_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        if (sample_vld) begin
            state_d = zc_next_state(state_q, hi, lo);
            // A crossing that lands on the saturating sample re-arms instead of timing out.
            if (rev && (!armed_q || at_max || near_max)) begin
                armed_d = 1'b1;
                cnt_clr = 1'b1;
            end else if (rev && (cnt_inc < MIN_P)) begin
                cnt_en = 1'b1;
            end else if (rev) begin
                period_d = cnt_inc;
                pvld_d   = 1'b1;
                locked_d = 1'b1;
                cnt_clr  = 1'b1;
            end else begin
                cnt_en = 1'b1;
                if (near_max) begin
                    tout_d   = 1'b1;
                    armed_d  = 1'b0;
                    locked_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            armed_q  <= 1'b0;
            locked_q <= 1'b0;
            period_q <= '0;
            pvld_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            armed_q  <= armed_d;
            locked_q <= locked_d;
            period_q <= period_d;
            pvld_q   <= pvld_d;
            tout_q   <= tout_d;
        end
    end

    assign period_out = period_q;
    assign period_vld = pvld_q;
    assign timeout    = tout_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_zero_cross_period.sv
// Directed bench: expected period/timeout pulses are queued as samples are driven
// and matched (value and cycle) by a monitor when the DUT pulses.
module tb_zero_cross_period;

    localparam int WIDTH      = 16;
    localparam int CNT_W      = 8;
    localparam int HYST       = 64;
    localparam int MIN_PERIOD = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    sample_vld = 1'b0;
    logic signed [WIDTH-1:0] sample_cur = '0;
    logic signed [WIDTH-1:0] sample_prev = '0;
    logic        [CNT_W-1:0] period_out;
    logic                    period_vld;
    logic                    timeout;
    logic                    locked;

    typedef struct {
        bit is_to;
        int val;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_cur = 0;

    zero_cross_period #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .HYST(HYST), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_vld  (sample_vld),
        .sample_cur  (sample_cur),
        .sample_prev (sample_prev),
        .period_out  (period_out),
        .period_vld  (period_vld),
        .timeout     (timeout),
        .locked      (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Scoreboard monitor: every pulse must match the queue head, and no head may go stale.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_pulse_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (period_vld || timeout) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'b0, period_vld, timeout}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'b0, period_vld, timeout}, e.is_to ? 32'd1 : 32'd2);
                if (!e.is_to)
                    check("period_value", 32'(period_out), e.val);
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input int cur, input int prev, input bit exp_to, input int exp_period);
        sample_vld  = 1'b1;
        sample_cur  = 16'(cur);
        sample_prev = 16'(prev);
        if (exp_period > 0) exp_q.push_back('{1'b0, exp_period, cyc + 1});
        if (exp_to)         exp_q.push_back('{1'b1, 0, cyc + 1});
        last_cur = cur;
        @(negedge clk);
    endtask

    task automatic wave(input int cur, input int exp_period);
        drive(cur, last_cur, 1'b0, exp_period);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sample_vld  = 1'b0;
            sample_cur  = 16'($urandom);
            sample_prev = 16'($urandom);
            @(negedge clk);
        end
    endtask

    // 4 low then 4 high samples; the rising crossing is accepted on the 2nd high sample.
    task automatic period8(input int gap, input int exp_period);
        for (int i = 0; i < 8; i++) begin
            wave((i < 4) ? -1000 : 1000, (i == 5) ? exp_period : 0);
            idle(gap);
        end
    endtask

    task automatic do_reset();
        sample_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_cur = 0;
    endtask

    initial begin
        // Reset state, asserted asynchronously before any clock edge.
        #1 rst = 1'b1;
        #2;
        check("reset_period_out", 32'(period_out), 32'd0);
        check("reset_period_vld", 32'(period_vld), 32'd0);
        check("reset_timeout",    32'(timeout),    32'd0);
        check("reset_locked",     32'(locked),     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Square wave, valid every cycle: first rise only arms.
        period8(0, 0);
        check("t1_unlocked_after_first_rise", 32'(locked), 32'd0);
        repeat (3) period8(0, 8);
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_period_out", 32'(period_out), 32'd8);

        // Same wave with two idle cycles between valid samples.
        repeat (3) period8(2, 8);

        // Spike on cur only inside the low half: not a crossing.
        wave(-1000, 0);
        wave(-1000, 0);
        drive(1000, -1000, 1'b0, 0);
        wave(-1000, 0);
        check("t3_period_held", 32'(period_out), 32'd8);
        wave(1000, 0);
        wave(1000, 8);
        wave(1000, 0);
        wave(1000, 0);
        idle(2);
        check("t3_queue_drained", exp_q.size(), 32'd0);

        // Noise below hysteresis never produces a crossing.
        do_reset();
        for (int i = 0; i < 40; i++)
            wave(int'($urandom_range(100)) - 50, 0);
        check("t4_locked", 32'(locked), 32'd0);
        check("t4_period_out", 32'(period_out), 32'd0);

        // Glitch two samples after the accepted edge, then a real edge at 10.
        do_reset();
        drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 0);
        drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 0);
        check("t5_glitch_no_period", 32'(period_out), 32'd0);
        repeat (6) drive(1000, 1000, 1'b0, 0);
        drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 10);
        check("t5_period_out", 32'(period_out), 32'd10);
        check("t5_locked", 32'(locked), 32'd1);

        // DC input saturates the counter at sample 255.
        for (int k = 1; k <= 300; k++) begin
            drive(-1000, -1000, k == 255, 0);
            if (k == 254) check("t6_locked_before_timeout", 32'(locked), 32'd1);
            if (k == 255) check("t6_unlocked_at_timeout", 32'(locked), 32'd0);
        end
        drive(1000, 1000, 1'b0, 0);
        check("t6_rearm_no_lock", 32'(locked), 32'd0);
        repeat (5) drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 6);
        check("t6_relocked", 32'(locked), 32'd1);

        // Crossing on the very sample that would saturate: re-arm, no timeout.
        repeat (254) drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 0);
        check("t6_sat_rev_locked", 32'(locked), 32'd1);
        check("t6_sat_rev_period", 32'(period_out), 32'd6);
        repeat (5) drive(-1000, -1000, 1'b0, 0);
        drive(1000, 1000, 1'b0, 6);

        // Asynchronous reset while the period pulse is high.
        #2 rst = 1'b1;
        #1;
        check("rst_mid_period_vld", 32'(period_vld), 32'd0);
        check("rst_mid_period_out", 32'(period_out), 32'd0);
        check("rst_mid_locked",     32'(locked),     32'd0);
        check("rst_mid_timeout",    32'(timeout),    32'd0);
        sample_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("final_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
